// File: rtl/port_arbiter_00_pkg.sv
// port_arbiter_00_pkg
// Shared definitions for the three-input packet arbiter:
//   - FSM state encoding (IDLE / LOCKED)
//   - input port index constants (E=0, S=1, L=2), also the bit positions
//     inside the one-hot grant vector {L,S,E}
//   - tail_bit(): position of the tail flag inside a flit of given width
package port_arbiter_00_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] PORT_E = 2'd0;
  localparam logic [1:0] PORT_S = 2'd1;
  localparam logic [1:0] PORT_L = 2'd2;

  // The tail flag is always the most significant flit bit.
  function automatic int tail_bit(input int datasize);
    return datasize - 1;
  endfunction

endpackage

// File: rtl/port_arbiter_00_rr_pick3.sv
// rr_pick3
// Purely combinational 3-way rotating-priority picker.
// Ports:
//   req_i [2:0]  requests, bit index = port index (E=0, S=1, L=2)
//   ptr_i [1:0]  highest-priority index this cycle (0..2; 3 is never driven)
//   gnt_o [2:0]  one-hot winner: first request found at or after ptr_i,
//                scanning ptr_i, ptr_i+1, ptr_i+2 modulo 3
//   any_o        at least one request present
module rr_pick3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o,
  output logic       any_o
);

  logic [2:0] sum;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o = 3'b000;
    found = 1'b0;
    sum   = 3'b000;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr_i} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/port_arbiter_00.sv
// port_arbiter_00
// Packet-locking arbiter merging three first-word-fall-through FIFOs (E, S, L)
// onto one registered output link. Once a requester is granted it owns the
// link until its tail flit (bit DATASIZE-1) has been popped.
//
// Ports:
//   fifo_clk                          clock, all state on rising edge
//   rst                               asynchronous active-high reset
//   {E,S,L}_data_in  [DATASIZE-1:0]   head flit of each input FIFO
//   {E,S,L}_valid_in                  input FIFO non-empty
//   {E,S,L}_pressure_in [WIDTH:0]     input FIFO occupancy
//   fifo_ready_{E,S,L}                pop strobe to each input FIFO
//   out_data [DATASIZE-1:0]           registered output flit
//   out_valid                         out_data holds a flit
//   out_ready                         downstream can accept
//   grant [2:0]                       one-hot owner {L,S,E}
//   busy                              packet lock held
//
// Build option: define PRESSURE_ARB_EN to pick, when idle, the valid
// requester with the largest pressure (ties resolved in round-robin order).
// Without it the pick is plain round-robin and pressures are ignored.
module port_arbiter_00 #(
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40
) (
  input  logic                fifo_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                E_valid_in,
  input  logic                S_valid_in,
  input  logic                L_valid_in,
  input  logic [WIDTH:0]      E_pressure_in,
  input  logic [WIDTH:0]      S_pressure_in,
  input  logic [WIDTH:0]      L_pressure_in,
  output logic                fifo_ready_E,
  output logic                fifo_ready_S,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          grant,
  output logic                busy
);

  import port_arbiter_00_pkg::*;

  localparam int TAIL = tail_bit(DATASIZE);

  logic [0:0]          state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [1:0]          rr_q, rr_d;
  logic [DATASIZE-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic [2:0]          valid_vec;
  logic [2:0]          pick_req;
  logic [2:0]          pick_gnt;
  logic                pick_any;
  logic                slot_free;
  logic [2:0]          pop_vec;
  logic                any_pop;
  logic [DATASIZE-1:0] pop_flit;
  logic [1:0]          rr_after;

  assign valid_vec = {L_valid_in, S_valid_in, E_valid_in};

`ifdef PRESSURE_ARB_EN
  // Only the valid requesters sharing the highest pressure go to the picker,
  // so the rotating picker itself resolves ties in round-robin order.
  logic [WIDTH:0] max_p;
  always_comb begin
    max_p = '0;
    if (E_valid_in && (E_pressure_in > max_p)) max_p = E_pressure_in;
    if (S_valid_in && (S_pressure_in > max_p)) max_p = S_pressure_in;
    if (L_valid_in && (L_pressure_in > max_p)) max_p = L_pressure_in;
    pick_req = valid_vec & {(L_pressure_in == max_p),
                            (S_pressure_in == max_p),
                            (E_pressure_in == max_p)};
  end
`else
  logic unused_pressure;
  assign unused_pressure = ^{E_pressure_in, S_pressure_in, L_pressure_in};
  assign pick_req        = valid_vec;
`endif

  rr_pick3 u_pick (
    .req_i (pick_req),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  assign slot_free = !out_valid_q || out_ready;

  // Pops only while locked; grant is one-hot so at most one strobe is high.
  // rst also gates the strobes so no pop can leak while reset is asserted.
  assign pop_vec = (state_q == ST_LOCKED && slot_free && !rst) ? (grant_q & valid_vec)
                                                               : 3'b000;
  assign any_pop = |pop_vec;

  always_comb begin
    pop_flit = E_data_in;
    if (grant_q[PORT_S])      pop_flit = S_data_in;
    else if (grant_q[PORT_L]) pop_flit = L_data_in;
  end

  // Round-robin pointer moves to the port after the one finishing a packet.
  always_comb begin
    rr_after = PORT_E;
    if (grant_q[PORT_E])      rr_after = PORT_S;
    else if (grant_q[PORT_S]) rr_after = PORT_L;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    // Output register: load on pop (also covers simultaneous drain+load),
    // drain when accepted with nothing new, otherwise hold.
    if (any_pop) begin
      out_data_d  = pop_flit;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = ST_LOCKED;
        end
      end
      default: begin
        if (any_pop && pop_flit[TAIL]) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
          rr_d    = rr_after;
        end
      end
    endcase
  end

  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 3'b000;
      rr_q        <= PORT_E;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_ready_E = pop_vec[0];
  assign fifo_ready_S = pop_vec[1];
  assign fifo_ready_L = pop_vec[2];
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign grant        = grant_q;
  assign busy         = (state_q == ST_LOCKED);

endmodule
